// File: rtl/ntt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_sched_pkg
// Description : Shared state encoding, widths and defaults for the NTT stage
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_sched_pkg;

    localparam int STAGE_W         = 3;
    localparam int DEF_DRAIN_CYC   = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_K1_RUN   = 3'd1,
        ST_K1_DRAIN = 3'd2,
        ST_K2_RUN   = 3'd3,
        ST_K2_DRAIN = 3'd4,
        ST_DONE     = 3'd5
    } sched_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_down_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sched_down_cnt
// Description : Loadable down-counter with enable and zero flag; holds at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_down_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ntt_stage_sched.sv
`default_nettype none
// ============================================================================
// Module      : ntt_stage_sched
// Description : Sequences K1_STAGES k1 AGU passes then one k2 pass, with a
//               drain gap after each. Optional watchdog: SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_stage_sched
    import ntt_sched_pkg::*;
#(
    parameter int K1_STAGES   = 2,
    parameter int DRAIN_CYC   = DEF_DRAIN_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               AGU_done_k1,
    input  logic               AGU_done_k2,
    output logic               AGU_enable_k1,
    output logic               AGU_enable_k2,
    output logic [STAGE_W-1:0] stage_idx,
    output logic               busy,
    output logic               done,
    output logic               timeout_err
);

    localparam int                   DRAIN_W      = cnt_width(DRAIN_CYC);
    localparam logic [DRAIN_W-1:0]   C_DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [STAGE_W-1:0]   C_LAST_K1    = (K1_STAGES > 0) ? STAGE_W'(K1_STAGES - 1) : '0;

    sched_state_e       r_state, w_next_state;
    logic [STAGE_W-1:0] r_stage_idx, w_next_stage_idx;
    logic               r_en_k1, r_en_k2, r_busy, r_done;
    logic               w_en_k1, w_en_k2, w_busy, w_done;
    logic               w_drain_load, w_drain_en, w_drain_zero;
    logic               w_timeout, w_start_ok;

    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;

    // State and Moore outputs share one register stage so outputs track state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_stage_idx <= '0;
            r_en_k1     <= 1'b0;
            r_en_k2     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_stage_idx <= w_next_stage_idx;
            r_en_k1     <= w_en_k1;
            r_en_k2     <= w_en_k2;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_stage_idx = r_stage_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state     = (K1_STAGES > 0) ? ST_K1_RUN : ST_K2_RUN;
                    w_next_stage_idx = '0;
                end
            end
            ST_K1_RUN:   if (AGU_done_k1) w_next_state = ST_K1_DRAIN;
            ST_K1_DRAIN: begin
                if (w_drain_zero) begin
                    if (r_stage_idx < C_LAST_K1) begin
                        w_next_state     = ST_K1_RUN;
                        w_next_stage_idx = r_stage_idx + 1'b1;
                    end else begin
                        w_next_state = ST_K2_RUN;
                    end
                end
            end
            ST_K2_RUN:   if (AGU_done_k2) w_next_state = ST_K2_DRAIN;
            ST_K2_DRAIN: begin
                if (w_drain_zero) begin
                    w_next_state     = ST_DONE;
                    w_next_stage_idx = '0;
                end
            end
            ST_DONE: begin
                w_next_state     = ST_IDLE;
                w_next_stage_idx = '0;
            end
            default: begin
                w_next_state     = ST_IDLE;
                w_next_stage_idx = '0;
            end
        endcase
        // Abort and watchdog expiry outrank every other transition.
        if ((r_state != ST_IDLE) && (abort || w_timeout)) begin
            w_next_state     = ST_IDLE;
            w_next_stage_idx = '0;
        end
    end

    always_comb begin
        w_en_k1 = (w_next_state == ST_K1_RUN);
        w_en_k2 = (w_next_state == ST_K2_RUN);
        w_busy  = (w_next_state == ST_K1_RUN) || (w_next_state == ST_K1_DRAIN) ||
                  (w_next_state == ST_K2_RUN) || (w_next_state == ST_K2_DRAIN);
        w_done  = (w_next_state == ST_DONE);
    end

    assign w_drain_load = ((r_state == ST_K1_RUN) && (w_next_state == ST_K1_DRAIN)) ||
                          ((r_state == ST_K2_RUN) && (w_next_state == ST_K2_DRAIN));
    assign w_drain_en   = (r_state == ST_K1_DRAIN) || (r_state == ST_K2_DRAIN);

    sched_down_cnt #(.WIDTH(DRAIN_W)) u_drain_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_drain_load),
        .load_val (C_DRAIN_LOAD),
        .en       (w_drain_en),
        .zero     (w_drain_zero)
    );

`ifdef SCHED_TIMEOUT_EN
    localparam int                WD_W      = cnt_width(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]   C_WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

    logic w_wd_load, w_wd_en, w_wd_zero, r_timeout_err;

    // Loaded with TIMEOUT_CYC-1 so zero marks the TIMEOUT_CYC-th RUN cycle.
    assign w_wd_load = ((w_next_state == ST_K1_RUN) && (r_state != ST_K1_RUN)) ||
                       ((w_next_state == ST_K2_RUN) && (r_state != ST_K2_RUN));
    assign w_wd_en   = (r_state == ST_K1_RUN) || (r_state == ST_K2_RUN);
    assign w_timeout = w_wd_zero && (((r_state == ST_K1_RUN) && !AGU_done_k1) ||
                                     ((r_state == ST_K2_RUN) && !AGU_done_k2));

    sched_down_cnt #(.WIDTH(WD_W)) u_wd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_wd_load),
        .load_val (C_WD_LOAD),
        .en       (w_wd_en),
        .zero     (w_wd_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout_err <= 1'b0;
        end else if (w_start_ok) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout && !abort) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYC;
    assign w_timeout            = 1'b0;
    assign timeout_err          = 1'b0;
`endif

    assign AGU_enable_k1 = r_en_k1;
    assign AGU_enable_k2 = r_en_k2;
    assign stage_idx     = r_stage_idx;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ntt_stage_sched
// Description : Self-checking bench for ntt_stage_sched (K1=2/DRAIN=4 and
//               K1=0/DRAIN=1 instances); timeout cases follow SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_stage_sched;

    localparam int K1    = 2;
    localparam int DRAIN = 4;
    localparam int TO    = 16;

    typedef struct packed {
        logic       en1;
        logic       en2;
        logic       busy;
        logic [2:0] stage;
        logic       done;
        logic       terr;
    } outs_t;

    typedef struct {
        logic  start;
        logic  abort;
        logic  d1;
        logic  d2;
        outs_t exp;
    } vec_t;

    localparam outs_t IDLE_O = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, done1, done2;
    logic       en1, en2, busy, done_o, terr;
    logic [2:0] stage;
    logic       z_start, z_abort, z_d1, z_d2;
    logic       z_en1, z_en2, z_busy, z_done, z_terr;
    logic [2:0] z_stage;

    int n_checks = 0;
    int n_pass   = 0;

    // AGU model state
    int c1 = 0, c2 = 0, k1_pass = 0, cur_lat1 = 0, lat2 = 0;
    int lat_k1 [2];
    bit stale = 1'b0;
    outs_t tl[$];

    ntt_stage_sched #(.K1_STAGES(K1), .DRAIN_CYC(DRAIN), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .AGU_done_k1(done1), .AGU_done_k2(done2),
        .AGU_enable_k1(en1), .AGU_enable_k2(en2), .stage_idx(stage),
        .busy(busy), .done(done_o), .timeout_err(terr)
    );

    ntt_stage_sched #(.K1_STAGES(0), .DRAIN_CYC(1), .TIMEOUT_CYC(TO)) dut0 (
        .clk(clk), .rst(rst), .start(z_start), .abort(z_abort),
        .AGU_done_k1(z_d1), .AGU_done_k2(z_d2),
        .AGU_enable_k1(z_en1), .AGU_enable_k2(z_en2), .stage_idx(z_stage),
        .busy(z_busy), .done(z_done), .timeout_err(z_terr)
    );

    function automatic outs_t mk(input bit e1, input bit e2, input bit b,
                                 input int st, input bit d, input bit t);
        outs_t o;
        o.en1 = e1; o.en2 = e2; o.busy = b; o.stage = 3'(st); o.done = d; o.terr = t;
        return o;
    endfunction

    function automatic outs_t cur();
        return {en1, en2, busy, stage, done_o, terr};
    endfunction

    function automatic outs_t cur0();
        return {z_en1, z_en2, z_busy, z_stage, z_done, z_terr};
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s t=%0t got=%b expected=%b (en1 en2 busy stage[3] done terr)",
                     name, $time, got, exp);
        else
            n_pass++;
    endtask

    // AGU: done rises N cycles after enable rises, follows enable down.
    task automatic agu_step();
        if (en1) c1++; else c1 = 0;
        if (en2) c2++; else c2 = 0;
        if (en1 && c1 == 1) begin
            cur_lat1 = lat_k1[k1_pass % 2];
            k1_pass++;
        end
        done1 = en1 ? (c1 > cur_lat1) : stale;
        done2 = en2 ? (c2 > lat2) : stale;
    endtask

    // Expected per-cycle outputs of a full run, starting the cycle after start.
    task automatic build(input int n0, input int n1, input int n2);
        int n;
        tl.delete();
        for (int p = 0; p < K1; p++) begin
            n = (p == 0) ? n0 : n1;
            repeat (n + 1) tl.push_back(mk(1, 0, 1, p, 0, 0));
            repeat (DRAIN) tl.push_back(mk(0, 0, 1, p, 0, 0));
        end
        repeat (n2 + 1) tl.push_back(mk(0, 1, 1, K1 - 1, 0, 0));
        repeat (DRAIN) tl.push_back(mk(0, 0, 1, K1 - 1, 0, 0));
        tl.push_back(mk(0, 0, 0, 0, 1, 0));
    endtask

    task automatic run(input string name, input int n0, input int n1, input int n2,
                       input int abort_at, input bit stl, input bit hold);
        build(n0, n1, n2);
        lat_k1[0] = n0; lat_k1[1] = n1; lat2 = n2; k1_pass = 0; stale = stl;
        @(negedge clk); check({name, "_idle"}, cur(), IDLE_O); agu_step();
        start = 1'b1; abort = 1'b0;
        for (int i = 0; i < tl.size(); i++) begin
            @(negedge clk); check(name, cur(), tl[i]); agu_step();
            start = hold; abort = (i == abort_at);
            if (i == abort_at) break;
        end
        @(negedge clk); check({name, "_after"}, cur(), IDLE_O); agu_step();
        abort = 1'b0;
        if (hold) begin
            @(negedge clk); check({name, "_restart"}, cur(), mk(1, 0, 1, 0, 0, 0)); agu_step();
            start = 1'b0; abort = 1'b1;
            @(negedge clk); check({name, "_abort"}, cur(), IDLE_O); agu_step();
            abort = 1'b0;
        end
        start = 1'b0; stale = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vt[14];
        int   n0, n1, n2, ab, len;
        bit   stl;

        vt[0]  = '{0, 0, 0, 0, IDLE_O};
        vt[1]  = '{1, 1, 0, 0, IDLE_O};
        vt[2]  = '{0, 0, 1, 1, IDLE_O};
        vt[3]  = '{1, 0, 0, 0, mk(0, 1, 1, 0, 0, 0)};
        vt[4]  = '{1, 0, 1, 0, mk(0, 1, 1, 0, 0, 0)};
        vt[5]  = '{0, 0, 0, 1, mk(0, 0, 1, 0, 0, 0)};
        vt[6]  = '{0, 0, 0, 1, mk(0, 0, 0, 0, 1, 0)};
        vt[7]  = '{1, 0, 0, 0, IDLE_O};
        vt[8]  = '{1, 0, 0, 0, mk(0, 1, 1, 0, 0, 0)};
        vt[9]  = '{0, 1, 0, 1, IDLE_O};
        vt[10] = '{1, 0, 0, 0, mk(0, 1, 1, 0, 0, 0)};
        vt[11] = '{0, 0, 0, 1, mk(0, 0, 1, 0, 0, 0)};
        vt[12] = '{0, 1, 0, 0, IDLE_O};
        vt[13] = '{0, 0, 0, 0, IDLE_O};

        rst = 1'b0; start = 1'b0; abort = 1'b0; done1 = 1'b0; done2 = 1'b0;
        z_start = 1'b0; z_abort = 1'b0; z_d1 = 1'b0; z_d2 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_main", cur(), IDLE_O);
        check("reset_k1zero", cur0(), IDLE_O);
        rst = 1'b1;

        // K1_STAGES=0 instance: cycle-by-cycle vectors
        for (int i = 0; i < 14; i++) begin
            z_start = vt[i].start; z_abort = vt[i].abort; z_d1 = vt[i].d1; z_d2 = vt[i].d2;
            @(negedge clk);
            check($sformatf("k1zero_vec%0d", i), cur0(), vt[i].exp);
        end
        z_start = 1'b0; z_abort = 1'b0; z_d1 = 1'b0; z_d2 = 1'b0;

        run("nominal", 8, 8, 8, -1, 1'b0, 1'b0);
        run("hold_start", 8, 8, 8, -1, 1'b0, 1'b1);
        run("stale_done", 5, 5, 5, -1, 1'b1, 1'b0);
        run("abort_k1_pass1", 8, 8, 8, (8 + 1 + DRAIN) + 2, 1'b0, 1'b0);
        repeat (12) begin
            @(negedge clk); check("post_abort_quiet", cur(), IDLE_O); agu_step();
        end

        for (int r = 0; r < 16; r++) begin
            n0 = $urandom_range(0, 6); n1 = $urandom_range(0, 6); n2 = $urandom_range(0, 6);
            stl = 1'($urandom_range(0, 1));
            len = (n0 + 1 + DRAIN) + (n1 + 1 + DRAIN) + (n2 + 1 + DRAIN) + 1;
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk); check("rand_gap", cur(), IDLE_O); agu_step();
            end
            run($sformatf("rand%0d", r), n0, n1, n2, ab, stl, 1'b0);
        end

        // AGU that never finishes
        lat_k1[0] = 1000; lat_k1[1] = 1000; lat2 = 1000; k1_pass = 0;
        @(negedge clk); check("hang_idle", cur(), IDLE_O); agu_step(); start = 1'b1;
`ifdef SCHED_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk); check("timeout_run", cur(), mk(1, 0, 1, 0, 0, 0)); agu_step();
            start = 1'b0;
        end
        @(negedge clk); check("timeout_fire", cur(), mk(0, 0, 0, 0, 0, 1)); agu_step();
        @(negedge clk); check("timeout_sticky", cur(), mk(0, 0, 0, 0, 0, 1)); agu_step();
        start = 1'b1;
        @(negedge clk); check("timeout_clear", cur(), mk(1, 0, 1, 0, 0, 0)); agu_step();
`else
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); check("no_watchdog_wait", cur(), mk(1, 0, 1, 0, 0, 0)); agu_step();
            start = 1'b0;
        end
`endif
        start = 1'b0; abort = 1'b1;
        @(negedge clk); check("hang_abort", cur(), IDLE_O); agu_step(); abort = 1'b0;

        // Asynchronous reset during the k2 pass
        build(3, 3, 6);
        lat_k1[0] = 3; lat_k1[1] = 3; lat2 = 6; k1_pass = 0;
        @(negedge clk); check("rstk2_idle", cur(), IDLE_O); agu_step(); start = 1'b1;
        for (int i = 0; i < tl.size(); i++) begin
            @(negedge clk); check("rstk2_run", cur(), tl[i]); agu_step(); start = 1'b0;
            if (i == 2 * (3 + 1 + DRAIN) + 2) begin
                #2 rst = 1'b0;
                #1 check("reset_async", cur(), IDLE_O);
                break;
            end
        end
        @(negedge clk); rst = 1'b1; agu_step();
        @(negedge clk); check("reset_release", cur(), IDLE_O); agu_step();
        run("post_reset", 2, 4, 3, -1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_stage_sched.md
# ntt_stage_sched

Stage scheduler for the NTT address-generation path. Accepts a start request, drives the k1-stage AGU enable for a configured number of passes, then drives the k2-stage AGU enable for the final pass. Between passes it inserts a drain gap so the downstream butterfly/memory pipeline can flush. It sits between the top-level NTT controller and the AGU_k1/AGU_k2 instances, and consumes their done flags.

## Interface
Parameters:
- K1_STAGES, default 2: number of k1 passes before the k2 pass; range 0..7.
- DRAIN_CYC, default 4: idle cycles inserted after each pass; range 1..15.
- TIMEOUT_CYC, default 1024: watchdog limit per pass; used only when SCHED_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- abort  in  1  level; returns to IDLE from any state.
- AGU_done_k1  in  1  done flag from the k1 AGU.
- AGU_done_k2  in  1  done flag from the k2 AGU.
- AGU_enable_k1  out  1  registered; high only in K1_RUN.
- AGU_enable_k2  out  1  registered; high only in K2_RUN.
- stage_idx  out  3  current k1 pass index.
- busy  out  1  high in K1_RUN, K1_DRAIN, K2_RUN, K2_DRAIN.
- done  out  1  one-cycle pulse on normal completion.
- timeout_err  out  1  sticky watchdog error flag.

## Operation
- FSM states: IDLE, K1_RUN, K1_DRAIN, K2_RUN, K2_DRAIN, DONE.
- All outputs are Moore and registered.
- Reset values of all outputs are 0; reset state is IDLE.
- IDLE with start=1 and abort=0:
  - K1_STAGES>0: go to K1_RUN, stage_idx=0.
  - K1_STAGES=0: go directly to K2_RUN.
  - Clears timeout_err.
- K1_RUN with AGU_done_k1=1: go to K1_DRAIN.
- K1_DRAIN:
  - Drain counter loads DRAIN_CYC-1 on entry and decrements each cycle.
  - At 0, if stage_idx<K1_STAGES-1: increment stage_idx and return to K1_RUN.
  - At 0 otherwise: go to K2_RUN.
- K2_RUN with AGU_done_k2=1: go to K2_DRAIN.
- K2_DRAIN: same counting as K1_DRAIN; at 0 go to DONE.
- DONE: done=1 for exactly that cycle; stage_idx=0; then IDLE unconditionally.
- Every pass is followed by at least one cycle with its enable low. This guarantees the AGU clears its j counter and done flag before the next pass.
- Done flags are ignored outside the matching RUN state. A stale done arriving during DRAIN has no effect.
- start is ignored outside IDLE, including in the DONE cycle.
- abort=1 in any non-IDLE state:
  - Next state IDLE; enables, busy and stage_idx go to 0.
  - No done pulse.
- Priority: abort over start; abort over done flags or drain expiry in the same cycle.
- Reset mid-pass: immediate return to IDLE with all outputs 0, regardless of phase.

## Timing
- Start accepted at edge N: busy=1 and the enable=1 at N+1.
- Done flag seen high at edge M: the enable drops at M+1.
- Next pass's enable rises at M+1+DRAIN_CYC.
- done pulses DRAIN_CYC+1 cycles after AGU_done_k2 is sampled.
- Total latency per pass: AGU run time + 1 + DRAIN_CYC cycles.

## Configuration
- SCHED_TIMEOUT_EN defined:
  - A watchdog counter of width $clog2(TIMEOUT_CYC+1) clears on entry to K1_RUN or K2_RUN and counts while in the RUN state.
  - Reaching TIMEOUT_CYC without the done flag forces IDLE (as abort) and sets timeout_err.
  - timeout_err stays set until the next accepted start.
- SCHED_TIMEOUT_EN undefined: no watchdog logic; the timeout_err port remains and is tied to 0.

## Structure
- Shared package ntt_sched_pkg:
  - sched_state_e enum (6 states, 3-bit encoding).
  - STAGE_W=3.
  - Default DRAIN_CYC and TIMEOUT_CYC constants.
- One sub-module, sched_down_cnt: a loadable down-counter with load, enable and zero flag.
  - Instantiated once for the drain gap.
  - Instantiated a second time for the watchdog when the macro is defined.

## Test plan
Bench uses an AGU behavioural model that raises done N cycles after its enable rises and clears done when the enable drops.

- Nominal run (K1_STAGES=2, DRAIN_CYC=4, N=8): pulse start → AGU_enable_k1 high twice (stage_idx 0 then 1), then AGU_enable_k2 once, with exactly 4 low cycles between them; done pulses once, 5 cycles after AGU_done_k2.
- K1_STAGES=0: start → AGU_enable_k2 rises the next cycle; AGU_enable_k1 never asserts.
- Abort during the second K1_RUN: busy, enables and stage_idx go to 0 the next cycle; no done pulse. Start and abort in the same IDLE cycle → stays IDLE.
- Start held high through DONE: exactly one done pulse, then a new run begins from IDLE. AGU_done_k1 forced high during K1_DRAIN → no extra pass.
- Timeout (SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, model never raises done): IDLE at cycle 17 of K1_RUN, timeout_err=1; next start clears it. Without the macro, timeout_err stays 0 and the FSM waits indefinitely.
- Reset asserted mid-K2_RUN: all outputs 0 immediately (asynchronous). After release, the FSM is in IDLE.
